// File: rtl/uart_file_xfer_ctrl_if.sv
// Bus bundle of the UART file-transfer engine: UART register bus,
// file-memory read port, received-byte stream and console stream.
interface uart_file_xfer_ctrl_if #(
    parameter int DATA_W  = 32,
    parameter int MADDR_W = 16
);
    logic               uart_sel;
    logic [2:0]         uart_addr;
    logic               uart_wr;
    logic               uart_rd;
    logic [31:0]        uart_di;
    logic [31:0]        uart_do;
    logic               uart_ready;
    logic               mem_rd;
    logic [MADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0]  mem_rdata;
    logic [7:0]         rx_data;
    logic               rx_valid;
    logic               rx_last;
    logic               rx_ready;
    logic [7:0]         con_char;
    logic               con_valid;

    modport master (
        output uart_sel, uart_addr, uart_wr, uart_rd, uart_di,
        input  uart_do, uart_ready,
        output mem_rd, mem_addr,
        input  mem_rdata,
        output rx_data, rx_valid, rx_last,
        input  rx_ready,
        output con_char, con_valid
    );

    modport slave (
        input  uart_sel, uart_addr, uart_wr, uart_rd, uart_di,
        output uart_do, uart_ready,
        input  mem_rd, mem_addr,
        output mem_rdata,
        input  rx_data, rx_valid, rx_last,
        output rx_ready,
        input  con_char, con_valid
    );
endinterface

// File: rtl/uart_file_xfer_ctrl.sv
// Host-side UART console / file-transfer engine driving an iob_uart
// register bus; sends files from word memory, streams received files out.
module uart_file_xfer_ctrl #(
    parameter int DATA_W    = 32,
    parameter int MADDR_W   = 16,
    parameter int SIZE_B    = 4,
    parameter int UART_DIVV = 868,
    parameter int CMD_SEND  = 2,
    parameter int CMD_RECV  = 3,
    parameter int CMD_END   = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    input  logic [31:0]           send_size,
    output logic                  busy,
    output logic                  done,
    uart_file_xfer_ctrl_if.master bus
);
    localparam logic [2:0] A_SOFT_RESET = 3'd0;
    localparam logic [2:0] A_RXEN       = 3'd1;
    localparam logic [2:0] A_DIV        = 3'd2;
    localparam logic [2:0] A_WRITE_WAIT = 3'd3;
    localparam logic [2:0] A_DATA       = 3'd4;
    localparam logic [2:0] A_READ_VALID = 3'd5;
    localparam logic [3:0] BPW_M1       = 4'(DATA_W / 8 - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_INIT_WR, S_INIT_NX,
        S_GC_POLL, S_GC_CHK, S_GC_DATA, S_GC_GOT, S_RX_HOLD,
        S_TX_NEXT, S_DT_RD, S_DT_LAT,
        S_PC_POLL, S_PC_CHK, S_PC_WR
    } state_t;

    typedef enum logic [2:0] {
        P_CMD, P_SZ_TX, P_DAT_TX, P_SZ_RX, P_DAT_RX
    } phase_t;

    state_t            state_q, state_n;
    phase_t            phase_q, phase_n;
    logic              busy_q, busy_n;
    logic              done_q, done_n;
    logic [1:0]        idx_q, idx_n;
    logic              flag_q, flag_n;
    logic [7:0]        byte_q, byte_n;
    logic [7:0]        tx_q, tx_n;
    logic [31:0]       cnt_q, cnt_n;
    logic [31:0]       len_q, len_n;
    logic [DATA_W-1:0] word_q, word_n;
    logic [3:0]        bidx_q, bidx_n;
    logic [31:0]       waddr_q, waddr_n;

    logic [2:0]        init_addr;
    logic [31:0]       init_data;
    logic [7:0]        len_byte;
    logic [7:0]        word_byte;
    logic              unused_do;

    assign busy      = busy_q;
    assign done      = done_q;
    assign len_byte  = 8'(len_q >> {cnt_q[28:0], 3'd0});
    assign word_byte = 8'(word_q >> {bidx_q, 3'd0});
    assign unused_do = ^bus.uart_do[31:8];

    always_comb begin
        init_addr = A_SOFT_RESET;
        init_data = 32'd0;
        unique case (idx_q)
            2'd0: init_data = 32'd1;
            2'd2: begin
                init_addr = A_DIV;
                init_data = 32'(UART_DIVV);
            end
            2'd3: begin
                init_addr = A_RXEN;
                init_data = 32'd1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            phase_q <= P_CMD;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            idx_q   <= 2'd0;
            flag_q  <= 1'b0;
            byte_q  <= 8'd0;
            tx_q    <= 8'd0;
            cnt_q   <= 32'd0;
            len_q   <= 32'd0;
            word_q  <= '0;
            bidx_q  <= 4'd0;
            waddr_q <= 32'd0;
        end else begin
            state_q <= state_n;
            phase_q <= phase_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
            idx_q   <= idx_n;
            flag_q  <= flag_n;
            byte_q  <= byte_n;
            tx_q    <= tx_n;
            cnt_q   <= cnt_n;
            len_q   <= len_n;
            word_q  <= word_n;
            bidx_q  <= bidx_n;
            waddr_q <= waddr_n;
        end
    end

    always_comb begin
        state_n = state_q;
        phase_n = phase_q;
        busy_n  = busy_q;
        done_n  = done_q;
        idx_n   = idx_q;
        flag_n  = flag_q;
        byte_n  = byte_q;
        tx_n    = tx_q;
        cnt_n   = cnt_q;
        len_n   = len_q;
        word_n  = word_q;
        bidx_n  = bidx_q;
        waddr_n = waddr_q;
        bus.uart_sel  = 1'b0;
        bus.uart_addr = 3'd0;
        bus.uart_wr   = 1'b0;
        bus.uart_rd   = 1'b0;
        bus.uart_di   = 32'd0;
        bus.mem_rd    = 1'b0;
        bus.mem_addr  = '0;
        bus.rx_data   = 8'd0;
        bus.rx_valid  = 1'b0;
        bus.rx_last   = 1'b0;
        bus.con_char  = 8'd0;
        bus.con_valid = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    busy_n  = 1'b1;
                    done_n  = 1'b0;
                    idx_n   = 2'd0;
                    state_n = S_INIT_WR;
                end
            end
            S_INIT_WR: begin
                bus.uart_sel  = 1'b1;
                bus.uart_wr   = 1'b1;
                bus.uart_addr = init_addr;
                bus.uart_di   = init_data;
                if (bus.uart_ready) state_n = S_INIT_NX;
            end
            S_INIT_NX: begin
                idx_n = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    phase_n = P_CMD;
                    state_n = S_GC_POLL;
                end else begin
                    state_n = S_INIT_WR;
                end
            end
            S_GC_POLL: begin
                bus.uart_sel  = 1'b1;
                bus.uart_rd   = 1'b1;
                bus.uart_addr = A_READ_VALID;
                if (bus.uart_ready) begin
                    flag_n  = bus.uart_do[0];
                    state_n = S_GC_CHK;
                end
            end
            S_GC_CHK: state_n = flag_q ? S_GC_DATA : S_GC_POLL;
            S_GC_DATA: begin
                bus.uart_sel  = 1'b1;
                bus.uart_rd   = 1'b1;
                bus.uart_addr = A_DATA;
                if (bus.uart_ready) begin
                    byte_n  = bus.uart_do[7:0];
                    state_n = S_GC_GOT;
                end
            end
            S_GC_GOT: begin
                state_n = S_GC_POLL;
                case (phase_q)
                    P_SZ_RX: begin
                        len_n = len_q | ({24'd0, byte_q} << {cnt_q[28:0], 3'd0});
                        cnt_n = cnt_q + 32'd1;
                        if (cnt_q == 32'(SIZE_B - 1)) begin
                            cnt_n   = 32'd0;
                            phase_n = (len_n == 32'd0) ? P_CMD : P_DAT_RX;
                        end
                    end
                    P_DAT_RX: state_n = S_RX_HOLD;
                    default: begin
                        unique case (1'b1)
                            byte_q == 8'(CMD_SEND): begin
                                len_n   = send_size;
                                cnt_n   = 32'd0;
                                phase_n = P_SZ_TX;
                                state_n = S_TX_NEXT;
                            end
                            byte_q == 8'(CMD_RECV): begin
                                len_n   = 32'd0;
                                cnt_n   = 32'd0;
                                phase_n = P_SZ_RX;
                            end
                            byte_q == 8'(CMD_END): begin
                                done_n  = 1'b1;
                                busy_n  = 1'b0;
                                state_n = S_IDLE;
                            end
                            default: begin
                                bus.con_valid = 1'b1;
                                bus.con_char  = byte_q;
                            end
                        endcase
                    end
                endcase
            end
            S_RX_HOLD: begin
                bus.rx_valid = 1'b1;
                bus.rx_data  = byte_q;
                bus.rx_last  = (cnt_q == len_q - 32'd1);
                if (bus.rx_ready) begin
                    state_n = S_GC_POLL;
                    if (cnt_q == len_q - 32'd1) begin
                        cnt_n   = 32'd0;
                        phase_n = P_CMD;
                    end else begin
                        cnt_n = cnt_q + 32'd1;
                    end
                end
            end
            S_TX_NEXT: begin
                if (phase_q == P_SZ_TX) begin
                    if (cnt_q == 32'(SIZE_B)) begin
                        cnt_n   = 32'd0;
                        bidx_n  = 4'd0;
                        waddr_n = 32'd0;
                        if (len_q == 32'd0) begin
                            phase_n = P_CMD;
                            state_n = S_GC_POLL;
                        end else begin
                            phase_n = P_DAT_TX;
                            state_n = S_DT_RD;
                        end
                    end else begin
                        tx_n    = len_byte;
                        state_n = S_PC_POLL;
                    end
                end else if (cnt_q == len_q) begin
                    phase_n = P_CMD;
                    state_n = S_GC_POLL;
                end else if (bidx_q == 4'd0) begin
                    state_n = S_DT_RD;
                end else begin
                    tx_n    = word_byte;
                    state_n = S_PC_POLL;
                end
            end
            S_DT_RD: begin
                bus.mem_rd   = 1'b1;
                bus.mem_addr = waddr_q[MADDR_W-1:0];
                state_n      = S_DT_LAT;
            end
            S_DT_LAT: begin
                word_n  = bus.mem_rdata;
                tx_n    = bus.mem_rdata[7:0];
                state_n = S_PC_POLL;
            end
            S_PC_POLL: begin
                bus.uart_sel  = 1'b1;
                bus.uart_rd   = 1'b1;
                bus.uart_addr = A_WRITE_WAIT;
                if (bus.uart_ready) begin
                    flag_n  = bus.uart_do[0];
                    state_n = S_PC_CHK;
                end
            end
            S_PC_CHK: state_n = flag_q ? S_PC_POLL : S_PC_WR;
            S_PC_WR: begin
                bus.uart_sel  = 1'b1;
                bus.uart_wr   = 1'b1;
                bus.uart_addr = A_DATA;
                bus.uart_di   = {24'd0, tx_q};
                if (bus.uart_ready) begin
                    cnt_n   = cnt_q + 32'd1;
                    state_n = S_TX_NEXT;
                    // advance to the next memory word once its last byte is out
                    if (phase_q == P_DAT_TX) begin
                        if (bidx_q == BPW_M1) begin
                            bidx_n  = 4'd0;
                            waddr_n = waddr_q + 32'd1;
                        end else begin
                            bidx_n = bidx_q + 4'd1;
                        end
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end
endmodule
